// File: rtl/console_pkg.sv
// Register map, bit positions and STATUS layout for the memory-mapped console.
// Shared by the top and bench so offsets live in one place.
package console_pkg;

  localparam logic [1:0] CON_TXDATA = 2'd0;
  localparam logic [1:0] CON_RXDATA = 2'd1;
  localparam logic [1:0] CON_STATUS = 2'd2;
  localparam logic [1:0] CON_CTRL   = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_OVF   = 5;

  localparam int CTRL_TX_EN    = 0;
  localparam int CTRL_LOOPBACK = 1;

  typedef struct packed {
    logic [7:0] rsvd_hi;
    logic [7:0] rx_count;
    logic [7:0] tx_count;
    logic [1:0] rsvd_lo;
    logic       rx_ovf;
    logic       tx_ovf;
    logic       rx_empty;
    logic       rx_full;
    logic       tx_empty;
    logic       tx_full;
  } con_status_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, head visible combinationally on rdata; push/pop take effect at the edge.
// Pop on empty is ignored; push on full only lands when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointers are exactly log2(DEPTH) wide, so increments wrap on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop_ok) begin
        rptr_q <= rptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/console_mmap.sv
// Memory-mapped byte console: TX/RX FIFOs behind a 4-word register window, valid/ready streams.
// rd is combinational; side effects at the access edge; TX drops on full (sticky), RX backpressures.
module console_mmap
  import console_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              re,
  input  logic              we,
  input  logic [31:2]       addr,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data
);

  localparam int CW = $clog2(DEPTH+1);

  logic [1:0]        sel;
  logic              tx_wr;
  logic              rx_rd;
  logic              st_wr;
  logic              ctrl_wr;

  logic              tx_en_q, tx_en_d;
  logic              loopback_q, loopback_d;
  logic              tx_ovf_q, tx_ovf_d;
  logic              rx_ovf_q, rx_ovf_d;

  logic              tx_push, tx_pop, tx_full, tx_empty, tx_drop;
  logic              rx_push, rx_pop, rx_full, rx_empty, rx_drop;
  logic [DATA_W-1:0] tx_head, rx_head, rx_wdata;
  logic [CW-1:0]     tx_count, rx_count;
  logic              lb_move;
  con_status_t       status;
  logic [31:0]       rx_word;
  logic              unused_bits;

  assign sel     = addr[3:2];
  assign tx_wr   = we & (sel == CON_TXDATA);
  assign rx_rd   = re & (sel == CON_RXDATA);
  assign st_wr   = we & (sel == CON_STATUS);
  assign ctrl_wr = we & (sel == CON_CTRL);

  assign unused_bits = ^{addr[31:4], wd};

  // In loopback the external ports go quiet and TX head feeds RX tail directly.
  assign lb_move  = loopback_q & tx_en_q & ~tx_empty & ~rx_full;
  assign tx_valid = ~tx_empty & tx_en_q & ~loopback_q;
  assign rx_ready = ~rx_full & ~loopback_q;
  assign tx_data  = tx_head;

  assign tx_push  = tx_wr;
  assign tx_pop   = (tx_valid & tx_ready) | lb_move;
  assign rx_push  = (rx_valid & rx_ready) | lb_move;
  assign rx_pop   = rx_rd & ~rx_empty;
  assign rx_wdata = loopback_q ? tx_head : rx_data;

  assign tx_drop  = tx_push & tx_full & ~tx_pop;
  assign rx_drop  = rx_push & rx_full & ~rx_pop;

  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (wd[DATA_W-1:0]),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rx_wdata),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // A new overflow beats a same-cycle W1C so no event is lost.
  always_comb begin
    tx_en_d    = tx_en_q;
    loopback_d = loopback_q;
    tx_ovf_d   = tx_drop | (tx_ovf_q & ~(st_wr & wd[ST_TX_OVF]));
    rx_ovf_d   = rx_drop | (rx_ovf_q & ~(st_wr & wd[ST_RX_OVF]));
    if (ctrl_wr) begin
      tx_en_d    = wd[CTRL_TX_EN];
      loopback_d = wd[CTRL_LOOPBACK];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_en_q    <= 1'b1;
      loopback_q <= 1'b0;
      tx_ovf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
    end else begin
      tx_en_q    <= tx_en_d;
      loopback_q <= loopback_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovf_q   <= rx_ovf_d;
    end
  end

  always_comb begin
    status          = '0;
    status.tx_full  = tx_full;
    status.tx_empty = tx_empty;
    status.rx_full  = rx_full;
    status.rx_empty = rx_empty;
    status.tx_ovf   = tx_ovf_q;
    status.rx_ovf   = rx_ovf_q;
    status.tx_count = 8'(tx_count);
    status.rx_count = 8'(rx_count);
  end

  always_comb begin
    rx_word = '0;
    if (!rx_empty) begin
      rx_word[31]         = 1'b1;
      rx_word[DATA_W-1:0] = rx_head;
    end
  end

  always_comb begin
    rd = '0;
    if (re) begin
      case (sel)
        CON_RXDATA: rd = rx_word;
        CON_STATUS: rd = status;
        CON_CTRL: begin
          rd[CTRL_TX_EN]    = tx_en_q;
          rd[CTRL_LOOPBACK] = loopback_q;
        end
        default: rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_console_mmap.sv
// Directed bench for console_mmap: register map, stream timing, overflow, loopback, async reset.
module tb_console_mmap;
  import console_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        re, we;
  logic [31:2] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic [7:0]  tx_data, rx_data;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] v;

  always #5 clk = ~clk;

  console_mmap #(.DEPTH(16), .DATA_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .re       (re),
    .we       (we),
    .addr     (addr),
    .wd       (wd),
    .rd       (rd),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_data  (rx_data)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [1:0] a);
    addr = {28'h3000000, a};
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    set_addr(a);
    wd = d;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] val);
    set_addr(a);
    re = 1'b1;
    #1;
    val = rd;
    tick();
    re = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; re = 1'b0; we = 1'b0; addr = '0; wd = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_rd: got %h want 00000000", rd); end
    n_checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_tx: valid %b data %h want 0 00", tx_valid, tx_data);
    end
    n_checks++;
    if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
    reset = 1'b0;
    tick();
    bus_read(CON_STATUS, v);
    n_checks++;
    if (v !== 32'h0000_000A) begin n_fail++; $display("FAIL reset_status: got %h want 0000000a", v); end
    bus_read(CON_CTRL, v);
    n_checks++;
    if (v !== 32'h0000_0001) begin n_fail++; $display("FAIL reset_ctrl: got %h want 00000001", v); end
    bus_read(CON_TXDATA, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL txdata_read: got %h want 00000000", v); end
  endtask

  task automatic test_tx_stream;
    tx_ready = 1'b1;
    set_addr(CON_TXDATA);
    wd = 32'h68; we = 1'b1;
    tick();
    wd = 32'h69;
    #1;
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h68) begin
      n_fail++; $display("FAIL tx_first: valid %b data %h want 1 68", tx_valid, tx_data);
    end
    tick();
    we = 1'b0;
    #1;
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h69) begin
      n_fail++; $display("FAIL tx_second: valid %b data %h want 1 69", tx_valid, tx_data);
    end
    tick();
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drained: valid %b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_tx_overflow;
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) bus_write(CON_TXDATA, 32'h10 + i);
    bus_read(CON_STATUS, v);
    n_checks++;
    if (v !== 32'h0000_1019) begin n_fail++; $display("FAIL ovf_status: got %h want 00001019", v); end
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h10) begin
      n_fail++; $display("FAIL ovf_head: valid %b data %h want 1 10", tx_valid, tx_data);
    end
    bus_write(CON_STATUS, 32'h10);
    bus_read(CON_STATUS, v);
    n_checks++;
    if (v !== 32'h0000_1009) begin n_fail++; $display("FAIL ovf_w1c: got %h want 00001009", v); end
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h10 + i)) begin
        n_fail++; $display("FAIL ovf_drain[%0d]: valid %b data %h want 1 %h", i, tx_valid, tx_data, 8'(8'h10 + i));
      end
      tick();
    end
    tx_ready = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_17th: valid %b data %h want 0", tx_valid, tx_data); end
  endtask

  task automatic test_full_push_pop;
    logic [7:0] exp;
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) bus_write(CON_TXDATA, 32'hA0 + i);
    set_addr(CON_TXDATA);
    wd = 32'hB0; we = 1'b1; tx_ready = 1'b1;
    tick();
    we = 1'b0; tx_ready = 1'b0;
    bus_read(CON_STATUS, v);
    n_checks++;
    if (v !== 32'h0000_1009) begin n_fail++; $display("FAIL full_pushpop_status: got %h want 00001009", v); end
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 8'(8'hA1 + i) : 8'hB0;
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp) begin
        n_fail++; $display("FAIL full_pushpop_drain[%0d]: valid %b data %h want 1 %h", i, tx_valid, tx_data, exp);
      end
      tick();
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_rx;
    rx_data = 8'h31; rx_valid = 1'b1;
    #1;
    n_checks++;
    if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_ready_idle: got %b want 1", rx_ready); end
    tick();
    rx_valid = 1'b0;
    bus_read(CON_STATUS, v);
    n_checks++;
    if (v !== 32'h0001_0002) begin n_fail++; $display("FAIL rx_first_status: got %h want 00010002", v); end
    rx_valid = 1'b1;
    rx_data = 8'h32; tick();
    rx_data = 8'h33; tick();
    rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_read(CON_RXDATA, v);
      n_checks++;
      if (v !== ((i < 3) ? (32'h8000_0031 + i) : 32'h0)) begin
        n_fail++; $display("FAIL rx_read[%0d]: got %h want %h", i, v, (i < 3) ? (32'h8000_0031 + i) : 32'h0);
      end
      bus_read(CON_STATUS, v);
      n_checks++;
      if (v[23:16] !== ((i < 3) ? 8'(2 - i) : 8'd0)) begin
        n_fail++; $display("FAIL rx_count[%0d]: got %0d want %0d", i, v[23:16], (i < 3) ? 2 - i : 0);
      end
    end
  endtask

  task automatic test_rx_backpressure;
    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'(8'h40 + i);
      tick();
    end
    rx_data = 8'h7F;
    #1;
    n_checks++;
    if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_full_ready: got %b want 0", rx_ready); end
    tick(); tick();
    rx_valid = 1'b0;
    bus_read(CON_STATUS, v);
    n_checks++;
    if (v !== 32'h0010_0006) begin n_fail++; $display("FAIL rx_full_status: got %h want 00100006", v); end
    for (int i = 0; i < 16; i++) begin
      bus_read(CON_RXDATA, v);
      n_checks++;
      if (v !== 32'h8000_0040 + i) begin
        n_fail++; $display("FAIL rx_full_drain[%0d]: got %h want %h", i, v, 32'h8000_0040 + i);
      end
    end
    bus_read(CON_RXDATA, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL rx_full_extra: got %h want 00000000", v); end
  endtask

  task automatic test_loopback;
    string s;
    s = "hello, rv32i!";
    bus_write(CON_CTRL, 32'h3);
    set_addr(CON_TXDATA);
    for (int i = 0; i < 13; i++) begin
      wd = {24'h0, s[i]}; we = 1'b1;
      #1;
      n_checks++;
      if (tx_valid !== 1'b0 || rx_ready !== 1'b0) begin
        n_fail++; $display("FAIL lb_ports[%0d]: tx_valid %b rx_ready %b want 0 0", i, tx_valid, rx_ready);
      end
      tick();
    end
    we = 1'b0;
    tick(); tick();
    bus_read(CON_STATUS, v);
    n_checks++;
    if (v !== 32'h000D_0002) begin n_fail++; $display("FAIL lb_status: got %h want 000d0002", v); end
    bus_read(CON_CTRL, v);
    n_checks++;
    if (v !== 32'h3) begin n_fail++; $display("FAIL lb_ctrl: got %h want 00000003", v); end
    for (int i = 0; i < 13; i++) begin
      bus_read(CON_RXDATA, v);
      n_checks++;
      if (v !== {1'b1, 23'h0, s[i]}) begin
        n_fail++; $display("FAIL lb_data[%0d]: got %h want %h", i, v, {1'b1, 23'h0, s[i]});
      end
    end
    bus_write(CON_CTRL, 32'h1);
  endtask

  task automatic test_reset_mid;
    bus_write(CON_CTRL, 32'h0);
    tx_ready = 1'b1;
    bus_write(CON_TXDATA, 32'h55);
    bus_write(CON_TXDATA, 32'h56);
    #1;
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_en_off: valid %b want 0", tx_valid); end
    rx_data = 8'h77; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    bus_read(CON_STATUS, v);
    n_checks++;
    if (v !== 32'h0001_0200) begin n_fail++; $display("FAIL pre_reset_status: got %h want 00010200", v); end
    set_addr(CON_STATUS);
    re = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (rd !== 32'h0000_000A) begin n_fail++; $display("FAIL async_reset_status: got %h want 0000000a", rd); end
    n_checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++; $display("FAIL async_reset_tx: valid %b data %h want 0 00", tx_valid, tx_data);
    end
    tick();
    reset = 1'b0;
    re = 1'b0;
    tick();
    bus_read(CON_CTRL, v);
    n_checks++;
    if (v !== 32'h1) begin n_fail++; $display("FAIL post_reset_ctrl: got %h want 00000001", v); end
    tx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_stream();
    test_tx_overflow();
    test_full_push_pop();
    test_rx();
    test_rx_backpressure();
    test_loopback();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
